// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter:
// access-width enum, arbiter FSM state enum and port index constants.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_DT_BYTE = 2'd0,
    MEM_DT_HALF = 2'd1,
    MEM_DT_WORD = 2'd2
  } mem_dt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_arb_st_e;

  localparam logic PORT_CORE   = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
// A lone request always wins; on contention the port that was not
// granted last wins.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic i_p0_req,
  input  logic i_p1_req,
  input  logic i_last,
  output logic o_any,
  output logic o_win
);

  // Pick the winning port from the two requests and the last-grant pointer
  always_comb begin
    o_any = i_p0_req | i_p1_req;
    o_win = PORT_CORE;
    if (i_p0_req && i_p1_req) begin
      o_win = (i_last == PORT_CORE) ? PORT_LOADER : PORT_CORE;
    end else if (i_p1_req) begin
      o_win = PORT_LOADER;
    end else begin
      o_win = PORT_CORE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter (port 0 = core, port 1 = loader/debug).
// IDLE -> BUSY -> DONE access sequence with a per-access wait timeout.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: round-robin on contention;
// when undefined port 0 always wins contention and no pointer exists.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wd,
  input  mem_dt_e     p0_dt,
  output logic [31:0] p0_rd,
  output logic        p0_ack,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wd,
  input  mem_dt_e     p1_dt,
  output logic [31:0] p1_rd,
  output logic        p1_ack,
  output logic        p1_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wd,
  output mem_dt_e     m_dt,
  input  logic [31:0] m_rd,
  input  logic        m_rdy,
  output logic        owner,
  output logic        busy
);

  localparam logic [16:0] LP_TIMEOUT = 17'(TIMEOUT_CYC);

  mem_arb_st_e r_state;
  mem_arb_st_e w_state_nxt;
  logic        r_owner;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  mem_dt_e     r_dt;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [16:0] w_cnt_inc;
  logic        w_rdy_hit;
  logic        w_tmo_hit;
  logic        w_any;
  logic        w_win;
  logic        w_last;
  logic        w_in_busy;
  logic        w_in_done;

  mem_arb_pick u_pick (
    .i_p0_req (p0_req),
    .i_p1_req (p1_req),
    .i_last   (w_last),
    .o_any    (w_any),
    .o_win    (w_win)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last;

  // Track which port received the most recent grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= PORT_LOADER;
    end else if ((r_state == ST_IDLE) && w_any) begin
      r_last <= w_win;
    end
  end

  assign w_last = r_last;
`else
  // A constant "port 1 went last" makes port 0 win every contention
  assign w_last = PORT_LOADER;
`endif

  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a ready in the final wait cycle beats the timeout
  always_comb begin
    w_state_nxt = r_state;
    w_rdy_hit   = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (m_rdy) begin
          w_rdy_hit   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_cnt_inc == LP_TIMEOUT) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch the winner's access on grant, then the result or timeout in BUSY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= PORT_CORE;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wd    <= 32'd0;
      r_dt    <= MEM_DT_WORD;
      r_cnt   <= 16'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_we    <= w_win ? p1_we   : p0_we;
            r_addr  <= w_win ? p1_addr : p0_addr;
            r_wd    <= w_win ? p1_wd   : p0_wd;
            r_dt    <= w_win ? p1_dt   : p0_dt;
            r_cnt   <= 16'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (w_rdy_hit) begin
            r_rdata <= m_rd;
            r_err   <= 1'b0;
          end else if (w_tmo_hit) begin
            r_cnt   <= w_cnt_inc[15:0];
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
          end else begin
            r_cnt   <= w_cnt_inc[15:0];
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign w_in_busy = (r_state == ST_BUSY);
  assign w_in_done = (r_state == ST_DONE);

  // Memory side is driven only from latched values
  assign m_req  = w_in_busy;
  assign m_we   = w_in_busy & r_we;
  assign m_addr = r_addr;
  assign m_wd   = r_wd;
  assign m_dt   = r_dt;

  // Completion is reported only to the owning port
  assign p0_ack = w_in_done & (r_owner == PORT_CORE);
  assign p1_ack = w_in_done & (r_owner == PORT_LOADER);
  assign p0_err = p0_ack & r_err;
  assign p1_err = p1_ack & r_err;
  assign p0_rd  = p0_ack ? r_rdata : 32'd0;
  assign p1_rd  = p1_ack ? r_rdata : 32'd0;

  assign owner = r_owner;
  assign busy  = (r_state != ST_IDLE);

endmodule
